// File: rtl/coin_pkg.sv
// coin_pkg: shared coin event type, default parameters and count-to-one-hot helper.
// Rev 1.0
`default_nettype none

package coin_pkg;

  localparam int NUM_COINS_DEF       = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 65536;
  localparam int GAP_CYCLES_DEF      = 33554432;
  localparam int FIFO_DEPTH_DEF      = 4;

  typedef logic [NUM_COINS_DEF-1:0] coin_evt_t;

  // A count of k selects coin k-1; counts outside 1..NUM_COINS_DEF give no coin.
  function automatic coin_evt_t onehot_of_count(input logic [7:0] count);
    coin_evt_t evt;
    evt = '0;
    for (int i = 0; i < NUM_COINS_DEF; i++) begin
      if (count == 8'(i + 1)) evt[i] = 1'b1;
    end
    return evt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coin_debounce.sv
// coin_debounce: 2-FF synchroniser and counter debouncer with registered edge strobes.
// Rev 1.0
`default_nettype none

module coin_debounce
  import coin_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // rise/fall are high for exactly the first cycle the new level is visible.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      level <= RESET_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/coin_pulse_decoder.sv
// coin_pulse_decoder: decodes coin pulse trains or manual buttons into one-hot events buffered in a FIFO.
// Rev 1.0
`default_nettype none

module coin_pulse_decoder
  import coin_pkg::*;
#(
  parameter int NUM_COINS       = NUM_COINS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int GAP_CYCLES      = GAP_CYCLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 UART_RXD,
  input  logic                 manualMode,
  input  logic [NUM_COINS-1:0] manualCoinL,
  output logic                 coin_valid,
  output logic [NUM_COINS-1:0] coin_data,
  input  logic                 coin_ready,
  output logic                 overflow,
  output logic [7:0]           bad_count
);

  localparam int PCW  = $clog2(NUM_COINS + 2);
  localparam int GCW  = $clog2(GAP_CYCLES);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [PCW-1:0] PULSE_SAT = PCW'(NUM_COINS + 1);

  logic                 rxd_level, rxd_rise, rxd_fall;
  logic [NUM_COINS-1:0] btn_level, btn_rise, btn_fall;
  logic                 unused_strobes;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_rxd_db (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (UART_RXD),
    .level    (rxd_level),
    .rise     (rxd_rise),
    .fall     (rxd_fall)
  );

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_btn_db
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_btn_db (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .din      (manualCoinL[i]),
      .level    (btn_level[i]),
      .rise     (btn_rise[i]),
      .fall     (btn_fall[i])
    );
  end

  assign unused_strobes = ^{rxd_level, rxd_fall, btn_level, btn_rise};

  // ---------------- pulse-train path ----------------
  logic [PCW-1:0]       pulse_cnt;
  logic [GCW-1:0]       gap_cnt;
  logic [NUM_COINS-1:0] pulse_onehot;
  logic                 train_close;

  assign train_close = (pulse_cnt != '0) && (gap_cnt == GCW'(GAP_CYCLES - 1)) && !rxd_rise;

  if (NUM_COINS == NUM_COINS_DEF) begin : g_pkg_onehot
    assign pulse_onehot = onehot_of_count(8'(pulse_cnt));
  end else begin : g_gen_onehot
    always_comb begin
      pulse_onehot = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
        if (pulse_cnt == PCW'(i + 1)) pulse_onehot[i] = 1'b1;
      end
    end
  end

  // Manual mode holds the decoder idle, which also discards any partial train.
  always_ff @(posedge CLOCK_50) begin
    if (reset || manualMode) begin
      pulse_cnt <= '0;
      gap_cnt   <= '0;
    end else if (rxd_rise) begin
      if (pulse_cnt != PULSE_SAT) pulse_cnt <= pulse_cnt + PCW'(1);
      gap_cnt <= '0;
    end else if (train_close) begin
      pulse_cnt <= '0;
      gap_cnt   <= '0;
    end else if (pulse_cnt != '0) begin
      gap_cnt <= gap_cnt + GCW'(1);
    end
  end

  // ---------------- event decision ----------------
  logic                 single_press;
  logic                 push;
  logic                 bad;
  logic [NUM_COINS-1:0] push_data;

  assign single_press = (btn_fall != '0) && ((btn_fall & (btn_fall - NUM_COINS'(1))) == '0);

  always_comb begin
    push      = 1'b0;
    bad       = 1'b0;
    push_data = '0;
    if (manualMode) begin
      if (single_press) begin
        push      = 1'b1;
        push_data = btn_fall;
      end else if (btn_fall != '0) begin
        bad = 1'b1;
      end
    end else if (train_close) begin
      if (pulse_cnt <= PCW'(NUM_COINS)) begin
        push      = 1'b1;
        push_data = pulse_onehot;
      end else begin
        bad = 1'b1;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [NUM_COINS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count;
  logic                 pop, full, do_push;

  assign pop     = coin_valid && coin_ready;
  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      bad_count <= 8'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      if (bad && bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
    end
  end

  // valid comes straight from the registered count, so coin_ready never reaches it.
  assign coin_valid = (count != '0);
  assign coin_data  = coin_valid ? mem[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_coin_pulse_decoder.sv
// tb_coin_pulse_decoder: directed table-driven bench for coin_pulse_decoder.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_coin_pulse_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       UART_RXD;
  logic       manualMode;
  logic [2:0] manualCoinL;
  logic       coin_valid;
  logic [2:0] coin_data;
  logic       coin_ready;
  logic       overflow;
  logic [7:0] bad_count;

  coin_pulse_decoder #(
    .NUM_COINS(3), .DEBOUNCE_CYCLES(4), .GAP_CYCLES(20), .FIFO_DEPTH(4)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .UART_RXD    (UART_RXD),
    .manualMode  (manualMode),
    .manualCoinL (manualCoinL),
    .coin_valid  (coin_valid),
    .coin_data   (coin_data),
    .coin_ready  (coin_ready),
    .overflow    (overflow),
    .bad_count   (bad_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Handshake log: every accepted event, sampled mid-cycle.
  logic [2:0] ev_q[$];
  int         valid_cycles = 0;
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (coin_valid) valid_cycles++;
      if (coin_valid && coin_ready) ev_q.push_back(coin_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_train(input int n, input int hi, input int lo);
    for (int p = 0; p < n; p++) begin
      UART_RXD = 1'b1;
      tick(hi);
      UART_RXD = 1'b0;
      tick(lo);
    end
  endtask

  task automatic press(input logic [2:0] mask, input int len);
    manualCoinL = ~mask;
    tick(len);
    manualCoinL = 3'b111;
    tick(len);
  endtask

  typedef struct {
    int         npulses;
    int         hi;
    int         lo;
    int         n_events;
    logic [2:0] data;
    int         bad_inc;
  } vec_t;

  vec_t       vecs[5];
  int         base;
  int         vbase;
  logic [7:0] bad0;
  logic [2:0] exp_seq[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2, 10, 10, 1, 3'b010, 0};
    vecs[1] = '{1,  3, 10, 0, 3'b000, 0};
    vecs[2] = '{4, 10, 10, 0, 3'b000, 1};
    vecs[3] = '{1, 10, 10, 1, 3'b001, 0};
    vecs[4] = '{3,  6,  6, 1, 3'b100, 0};

    reset       = 1'b1;
    UART_RXD    = 1'b0;
    manualMode  = 1'b0;
    manualCoinL = 3'b111;
    coin_ready  = 1'b1;
    tick(3);
    check("reset valid",     int'(coin_valid), 0);
    check("reset data",      int'(coin_data),  0);
    check("reset overflow",  int'(overflow),   0);
    check("reset bad_count", int'(bad_count),  0);
    reset = 1'b0;
    tick(2);

    // Pulse-train vectors
    for (int v = 0; v < 5; v++) begin
      base  = ev_q.size();
      vbase = valid_cycles;
      bad0  = bad_count;
      send_train(vecs[v].npulses, vecs[v].hi, vecs[v].lo);
      tick(60);
      check($sformatf("vec%0d events", v), ev_q.size() - base, vecs[v].n_events);
      check($sformatf("vec%0d valid_cycles", v), valid_cycles - vbase, vecs[v].n_events);
      if (vecs[v].n_events > 0)
        check($sformatf("vec%0d data", v), int'(ev_q[base]), int'(vecs[v].data));
      check($sformatf("vec%0d bad_inc", v), int'(bad_count) - int'(bad0), vecs[v].bad_inc);
    end

    // Overflow: five single-pulse trains into a stalled 4-entry FIFO
    coin_ready = 1'b0;
    base = ev_q.size();
    for (int k = 0; k < 5; k++) send_train(1, 10, 40);
    tick(30);
    check("ovf held valid", int'(coin_valid), 1);
    check("ovf head data",  int'(coin_data),  3'b001);
    check("ovf flag",       int'(overflow),   1);
    check("ovf no pops",    ev_q.size() - base, 0);
    coin_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d valid", k), int'(coin_valid), 1);
      check($sformatf("drain%0d data", k),  int'(coin_data),  3'b001);
      tick(1);
    end
    check("drain empty", int'(coin_valid), 0);

    // Reset during an open train with a non-empty FIFO
    coin_ready = 1'b0;
    send_train(1, 10, 40);
    tick(10);
    check("pre-reset valid", int'(coin_valid), 1);
    send_train(2, 10, 10);
    reset = 1'b1;
    tick(1);
    check("midreset valid",     int'(coin_valid), 0);
    check("midreset data",      int'(coin_data),  0);
    check("midreset overflow",  int'(overflow),   0);
    check("midreset bad_count", int'(bad_count),  0);
    reset      = 1'b0;
    coin_ready = 1'b1;
    base = ev_q.size();
    send_train(1, 10, 10);
    tick(40);
    check("post-reset events", ev_q.size() - base, 1);
    if (ev_q.size() > base) check("post-reset data", int'(ev_q[base]), 3'b001);

    // Mode switch mid-train discards silently
    base = ev_q.size();
    bad0 = bad_count;
    send_train(2, 10, 10);
    manualMode = 1'b1;
    tick(5);
    manualMode = 1'b0;
    tick(60);
    check("modesw events",  ev_q.size() - base, 0);
    check("modesw bad_inc", int'(bad_count) - int'(bad0), 0);

    // Manual buttons
    manualMode = 1'b1;
    tick(2);
    base = ev_q.size();
    press(3'b100, 10);
    tick(10);
    check("btn2 events", ev_q.size() - base, 1);
    if (ev_q.size() > base) check("btn2 data", int'(ev_q[base]), 3'b100);
    base = ev_q.size();
    bad0 = bad_count;
    press(3'b011, 10);
    tick(10);
    check("multi events",  ev_q.size() - base, 0);
    check("multi bad_inc", int'(bad_count) - int'(bad0), 1);

    // Full FIFO with push and pop in the same cycle
    coin_ready = 1'b0;
    press(3'b001, 8);
    press(3'b010, 8);
    press(3'b100, 8);
    press(3'b001, 8);
    tick(5);
    check("full valid",    int'(coin_valid), 1);
    check("full head",     int'(coin_data),  3'b001);
    check("full overflow", int'(overflow),   0);
    manualCoinL = 3'b101;
    tick(6);                 // button 1 fall strobe is now high: the decision cycle
    coin_ready = 1'b1;
    tick(1);
    coin_ready = 1'b0;
    check("pushpop overflow", int'(overflow),  0);
    check("pushpop head",     int'(coin_data), 3'b010);
    manualCoinL = 3'b111;
    tick(10);
    check("pushpop overflow late", int'(overflow), 0);
    exp_seq[0] = 3'b010;
    exp_seq[1] = 3'b100;
    exp_seq[2] = 3'b001;
    exp_seq[3] = 3'b010;
    base = ev_q.size();
    coin_ready = 1'b1;
    tick(8);
    check("pushpop drained", ev_q.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      if (ev_q.size() > base + k)
        check($sformatf("pushpop order%0d", k), int'(ev_q[base + k]), int'(exp_seq[k]));
    end
    check("pushpop empty", int'(coin_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
